// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common to tx and rx debug
// decoding), default bit timing and the link cipher key.
package uart_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_CLEANUP = 3'd4;

  localparam int         CLKS_PER_BIT_DEF = 434;
  localparam logic [7:0] CIPHER_KEY       = 8'h11;
endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with first-word fall-through read data; pointers carry one extra
// MSB so full and empty are distinguishable without an occupancy counter.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_wr, do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  // full is the pre-edge state, so a same-edge pop never frees room for a write
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_cipher.sv
// 8N1 UART transmitter: FIFO-buffered bytes are XOR-enciphered with KEY and
// shifted out LSB first between a start and a stop bit.
module uart_tx_cipher
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter logic [7:0] KEY          = CIPHER_KEY,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] tx_state
);
  localparam logic [11:0] CNT_LAST = 12'(CLKS_PER_BIT - 1);

  logic [2:0]  state;
  logic [11:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  head;
  logic        fifo_full, fifo_empty, pop;

  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign tx_ready = !fifo_full;
  assign busy     = (state != ST_IDLE) || !fifo_empty;
  assign tx_state = state;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      done    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= head ^ KEY;
            tx    <= 1'b0;
            cnt   <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == CNT_LAST) begin
            tx      <= shift[0];
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              // next bit goes on the line as the register shifts
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            done  <= 1'b1;
            state <= ST_CLEANUP;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        ST_CLEANUP: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          tx    <= 1'b1;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
